instr_fetch_unit: RTL

//  Fetch stage directly downstream of the instruction BRAM read port. It walks

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage behind a 1-cycle-latency instruction BRAM: walks addresses 0..max, delivers one
// instruction per cycle with valid/stall handshake, supports branch redirect/flush and done.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_max_addr,
  output logic [ADDR_W-1:0]  o_addr_read,
  input  logic [INSTR_W-1:0] i_instr_read,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid,
  input  logic               i_stall,
  input  logic               i_branch_en,
  input  logic [ADDR_W-1:0]  i_branch_addr,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_rd_pc;
  logic [ADDR_W-1:0]  r_max;
  logic               r_rd_pend;
  logic               r_last_issued;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_out_pc;

  logic w_busy;
  logic w_start;
  logic w_branch;
  logic w_blocked;
  logic w_issue;
  logic w_out_load;
  logic w_drain_done;

  always_comb begin
    w_busy       = (r_state == StFetch) || (r_state == StDrain);
    w_start      = i_start && ((r_state == StIdle) || (r_state == StDone));
    w_branch     = i_branch_en && w_busy;
    w_blocked    = r_valid && i_stall && r_rd_pend;
    w_issue      = (r_state == StFetch) && !w_blocked && !r_last_issued;
    w_out_load   = !r_valid || !i_stall;
    // Nothing pending and the output slot is empty or being consumed this edge.
    w_drain_done = !r_rd_pend && w_out_load;
  end

  // Replaying the in-flight address while blocked keeps the BRAM data stable.
  assign o_addr_read = w_blocked ? r_rd_pc : r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_pc          <= '0;
      r_rd_pc       <= '0;
      r_max         <= '0;
      r_last_issued <= 1'b0;
    end else if (w_start) begin
      r_state       <= StFetch;
      r_pc          <= '0;
      r_max         <= i_max_addr;
      r_last_issued <= 1'b0;
    end else if (w_branch) begin
      r_state       <= (i_branch_addr > r_max) ? StDone : StFetch;
      r_pc          <= i_branch_addr;
      r_last_issued <= 1'b0;
    end else if (w_issue) begin
      r_rd_pc <= r_pc;
      if (r_pc == r_max) begin
        r_last_issued <= 1'b1;
        r_state       <= StDrain;
      end else begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end else if ((r_state == StDrain) && w_drain_done) begin
      r_state <= StDone;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_pend <= 1'b0;
    end else if (w_branch) begin
      r_rd_pend <= 1'b0;
    end else if (w_issue) begin
      r_rd_pend <= 1'b1;
    end else if (!w_blocked) begin
      r_rd_pend <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
    end else if (w_branch) begin
      r_valid <= 1'b0;
    end else if (w_out_load) begin
      r_valid  <= r_rd_pend;
      r_instr  <= i_instr_read;
      r_out_pc <= r_rd_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_out_pc;
  assign o_valid = r_valid;
  assign o_busy  = w_busy;
  assign o_done  = (r_state == StDone);

endmodule
